pwm_stream_adapter: RTL and testbench
=====================================

PWM_STREAM_ADAPTER -- requirements
Module: pwm_stream_adapter

Interface
REQ-001 Parameter IN_W, default 16, FIFO sample width.
REQ-002 Parameter OUT_W, default 8, PWM sample width; IN_W >= 2*OUT_W SHALL hold.
REQ-003 Parameter NCH, default 1, channel count, legal range 1..4.
REQ-004 Parameter DIV, default 2500, clk110 cycles per frame (110 MHz / 44 kHz); DIV >= 3*NCH+4 SHALL hold.
REQ-005 Parameter CONV, default 1; 0 = MSB truncation, 1 = odd-bit decimation.
REQ-006 Parameter UNDER_HOLD, default 1; 1 = hold last sample on underrun, 0 = output midscale.
REQ-007 clk110  in  1  clock, 110 MHz.
REQ-008 RESET  in  1  reset, synchronous, active-low.
REQ-009 enable  in  1  run control; low halts frame fetching.
REQ-010 volume  in  3  attenuation, right-shift amount 0..7 about midscale.
REQ-011 fifo_data  in  IN_W  show-ahead FIFO head, valid while fifo_empty_n high.
REQ-012 fifo_empty_n  in  1  FIFO holds at least one sample.
REQ-013 fifo_rd  out  1  one-cycle pop strobe.
REQ-014 sample  out  NCH*OUT_W  channel k at bits [k*OUT_W +: OUT_W], unsigned.
REQ-015 sample_valid  out  1  one-cycle strobe, sample updated this cycle.
REQ-016 underrun_cnt  out  16  missing-sample count, saturating.

Function
REQ-017 Tick counter SHALL count 0..DIV-1 while enable high and wrap; tick = counter at DIV-1; enable low holds counter at 0.
REQ-018 FSM states: IDLE, FETCH, GAP, COMMIT; channel index ch cleared in IDLE.
REQ-019 IDLE -> FETCH on tick with enable high.
REQ-020 FETCH with fifo_empty_n high: capture converted fifo_data into staging[ch], assert fifo_rd that cycle only.
REQ-021 FETCH with fifo_empty_n low: staging[ch] = previous sample[ch] (UNDER_HOLD=1) or 2^(OUT_W-1) (UNDER_HOLD=0); fifo_rd low; underrun_cnt +1, saturating at 0xFFFF.
REQ-022 FETCH -> GAP if ch < NCH-1 (ch increments); FETCH -> COMMIT if ch = NCH-1; GAP -> FETCH next cycle; fifo_rd therefore never high on consecutive cycles.
REQ-023 COMMIT: all staging copied to sample simultaneously, sample_valid high one cycle, -> IDLE.
REQ-024 Tick arriving outside IDLE SHALL be ignored (DIV constraint makes this unreachable in legal use).
REQ-025 enable low in FETCH/GAP: abort to IDLE next cycle, no further fifo_rd, sample and staging unchanged, no sample_valid.
REQ-026 CONV=0: c = fifo_data[IN_W-1 -: OUT_W]; CONV=1: c bit i = fifo_data[2i+1].
REQ-027 Volume: out = 2^(OUT_W-1) + ((c - 2^(OUT_W-1)) >>> volume), computed signed at OUT_W+1 bits; result always in range, no clipping needed.
REQ-028 Volume sampled in FETCH cycle; underrun fill values not re-attenuated.
REQ-029 Latency: first fifo_rd on cycle after tick; sample_valid 2*NCH cycles after tick.

Reset
REQ-030 RESET low at a clk110 edge: FSM IDLE, tick counter 0, ch 0, fifo_rd 0, sample_valid 0, underrun_cnt 0, sample and staging all channels 2^(OUT_W-1) (0x80 for OUT_W=8).
REQ-031 RESET mid-frame: reset values apply next cycle, partial frame discarded, no sample_valid.

Verification
REQ-032 Defaults, FIFO head 0xAAAA, volume 0, enable high -> fifo_rd one cycle after tick, sample 0xFF, sample_valid 2 cycles after tick, ticks every 2500 cycles.
REQ-033 CONV=0, head 0x1234, volume 1 -> c 0x12, sample = 0x80 + (-0x6E>>>1) = 0x49.
REQ-034 NCH=2, FIFO holds 0xFF00 then 0x00FF, CONV=0 -> fifo_rd at tick+1 and tick+3, sample = {0x00,0xFF}, sample_valid at tick+4.
REQ-035 FIFO empty, UNDER_HOLD=1 then 0, 3 frames each -> sample holds last then 0x80, underrun_cnt 3 then 6, no fifo_rd; preload 0xFFFE -> saturates at 0xFFFF.
REQ-036 enable dropped in GAP of NCH=2 frame, or RESET pulsed mid-frame -> no sample_valid, single fifo_rd observed, sample unchanged (enable) or 0x80 (reset).

Source files
------------

// File: rtl/pwm_stream_adapter.sv
// Paces a show-ahead FIFO into per-channel PWM samples: one frame per DIV cycles,
// channels fetched on alternating cycles, all channels committed together.
module pwm_stream_adapter #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int NCH        = 1,
    parameter int DIV        = 2500,
    parameter int CONV       = 1,
    parameter int UNDER_HOLD = 1
) (
    input  logic                 clk110,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic [2:0]           volume,
    input  logic [IN_W-1:0]      fifo_data,
    input  logic                 fifo_empty_n,
    output logic                 fifo_rd,
    output logic [NCH*OUT_W-1:0] sample,
    output logic                 sample_valid,
    output logic [15:0]          underrun_cnt
);

    localparam int CNT_W = $clog2(DIV);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, GAP, COMMIT} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [NCH-1:0][OUT_W-1:0]     staging_q, staging_d;
    logic [NCH-1:0][OUT_W-1:0]     sample_q, sample_d;
    logic [15:0]                   underrun_q, underrun_d;
    logic                          tick;

    function automatic logic [OUT_W-1:0] convert(input logic [IN_W-1:0] d);
        logic [OUT_W-1:0] c;
        c = d[IN_W-1 -: OUT_W];
        if (CONV != 0) begin
            for (int i = 0; i < OUT_W; i++) c[i] = d[2*i+1];
        end
        return c;
    endfunction

    // Attenuation is a signed shift about midscale, so the result never leaves range.
    function automatic logic [OUT_W-1:0] attenuate(input logic [OUT_W-1:0] c,
                                                   input logic [2:0]       vol);
        logic signed [OUT_W:0] diff;
        logic signed [OUT_W:0] sum;
        diff = $signed({1'b0, c}) - $signed({1'b0, MID});
        sum  = (diff >>> vol) + $signed({1'b0, MID});
        return sum[OUT_W-1:0];
    endfunction

    assign tick         = (cnt_q == CNT_W'(DIV - 1));
    assign sample       = sample_q;
    assign underrun_cnt = underrun_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d      = state_q;
        ch_d         = ch_q;
        staging_d    = staging_q;
        sample_d     = sample_q;
        underrun_d   = underrun_q;
        fifo_rd      = 1'b0;
        sample_valid = 1'b0;

        if (!enable || tick) cnt_d = '0;
        else                 cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                ch_d = '0;
                if (tick && enable) state_d = FETCH;
            end
            FETCH: begin
                if (!enable) begin
                    state_d = IDLE;
                    ch_d    = '0;
                end else begin
                    if (fifo_empty_n) begin
                        fifo_rd        = 1'b1;
                        staging_d[ch_q] = attenuate(convert(fifo_data), volume);
                    end else begin
                        staging_d[ch_q] = (UNDER_HOLD != 0) ? sample_q[ch_q] : MID;
                        if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
                    end
                    // The last fetch loads sample on the same edge that enters COMMIT,
                    // so sample already holds the new frame while sample_valid is high.
                    if (ch_q == CH_W'(NCH - 1)) begin
                        state_d  = COMMIT;
                        sample_d = staging_d;
                    end else begin
                        state_d = GAP;
                        ch_d    = ch_q + CH_W'(1);
                    end
                end
            end
            GAP: begin
                if (enable) state_d = FETCH;
                else begin
                    state_d = IDLE;
                    ch_d    = '0;
                end
            end
            COMMIT: begin
                sample_valid = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk110) begin
        if (!RESET) begin
            // NOTE: staging and sample are small register arrays with a defined
            // midscale reset value, so they are reset rather than left undefined.
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            staging_q  <= {NCH{MID}};
            sample_q   <= {NCH{MID}};
            underrun_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            staging_q  <= staging_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pwm_stream_adapter.sv
// Three adapter configurations driven from a FIFO model; frame timing and sample
// values are predicted from the frame schedule and the conversion/volume arithmetic.
module tb_pwm_stream_adapter;

    localparam int P_DIV  [3] = '{2500, 16, 20};
    localparam int P_NCH  [3] = '{1, 1, 2};
    localparam int P_CONV [3] = '{1, 0, 0};
    localparam int P_UH   [3] = '{1, 1, 0};

    logic clk110 = 1'b0;
    always #5 clk110 = ~clk110;

    int cyc = 0;
    always @(posedge clk110) cyc <= cyc + 1;

    logic [2:0]       rst_n;
    logic [2:0]       en;
    logic [2:0][2:0]  vol;
    logic [2:0]       empty_n;
    logic [2:0][15:0] fdata;
    logic [2:0]       rd;
    logic [2:0]       vld;
    logic [2:0][15:0] ucnt;
    logic [7:0]       smp0, smp1;
    logic [15:0]      smp2;
    logic [2:0][15:0] smp;

    assign smp[0] = {8'h00, smp0};
    assign smp[1] = {8'h00, smp1};
    assign smp[2] = smp2;

    pwm_stream_adapter #(.IN_W(16), .OUT_W(8), .NCH(P_NCH[0]), .DIV(P_DIV[0]),
                         .CONV(P_CONV[0]), .UNDER_HOLD(P_UH[0])) u0 (
        .clk110(clk110), .RESET(rst_n[0]), .enable(en[0]), .volume(vol[0]),
        .fifo_data(fdata[0]), .fifo_empty_n(empty_n[0]), .fifo_rd(rd[0]),
        .sample(smp0), .sample_valid(vld[0]), .underrun_cnt(ucnt[0]));

    pwm_stream_adapter #(.IN_W(16), .OUT_W(8), .NCH(P_NCH[1]), .DIV(P_DIV[1]),
                         .CONV(P_CONV[1]), .UNDER_HOLD(P_UH[1])) u1 (
        .clk110(clk110), .RESET(rst_n[1]), .enable(en[1]), .volume(vol[1]),
        .fifo_data(fdata[1]), .fifo_empty_n(empty_n[1]), .fifo_rd(rd[1]),
        .sample(smp1), .sample_valid(vld[1]), .underrun_cnt(ucnt[1]));

    pwm_stream_adapter #(.IN_W(16), .OUT_W(8), .NCH(P_NCH[2]), .DIV(P_DIV[2]),
                         .CONV(P_CONV[2]), .UNDER_HOLD(P_UH[2])) u2 (
        .clk110(clk110), .RESET(rst_n[2]), .enable(en[2]), .volume(vol[2]),
        .fifo_data(fdata[2]), .fifo_empty_n(empty_n[2]), .fifo_rd(rd[2]),
        .sample(smp2), .sample_valid(vld[2]), .underrun_cnt(ucnt[2]));

    logic [15:0] fq      [3][$];
    int          rd_ev   [3][$];
    int          vld_ev  [3][$];
    logic [15:0] vld_smp [3][$];
    int          rd_last [3] = '{-10, -10, -10};
    logic [15:0] stim    [$];

    int          base    [3];
    int          nfr     [3];
    logic [15:0] model_s [3] = '{16'h0080, 16'h0080, 16'h8080};
    logic [15:0] uexp    [3] = '{16'h0000, 16'h0000, 16'h0000};

    int vectors     = 0;
    int miscompares = 0;

    // Event recorder, sampled mid-cycle.
    always @(negedge clk110) begin
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) begin
                rd_ev[i].push_back(cyc);
                rd_last[i] = cyc;
            end
            if (vld[i]) begin
                vld_ev[i].push_back(cyc);
                vld_smp[i].push_back(smp[i]);
            end
        end
    end

    // Show-ahead FIFO model: pop after the edge that consumed a strobed head.
    always @(posedge clk110) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rd_last[i] == cyc - 1 && fq[i].size() > 0) void'(fq[i].pop_front());
            empty_n[i] = (fq[i].size() > 0);
            fdata[i]   = (fq[i].size() > 0) ? fq[i][0] : 16'h0000;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_conv(input logic [15:0] d, input int cm, input int v);
        int c, s, dv, q;
        if (cm == 0) c = int'(d) / 256;
        else begin
            c = 0;
            for (int b = 0; b < 8; b++) if (d[2*b+1]) c += (1 << b);
        end
        s  = c - 128;
        dv = 1 << v;
        q  = (s >= 0) ? s / dv : -((-s + dv - 1) / dv);
        return 8'(128 + q);
    endfunction

    task automatic start(input int i);
        @(negedge clk110);
        rst_n[i] = 1'b1;
        en[i]    = 1'b1;
        base[i]  = cyc;
        nfr[i]   = 0;
    endtask

    task automatic clear_events(input int i);
        rd_ev[i].delete();
        vld_ev[i].delete();
        vld_smp[i].delete();
    endtask

    task automatic frame_check(input int i, input logic [15:0] exp_s, input int n_rd);
        int t, tv;
        t  = base[i] + P_DIV[i] - 1 + nfr[i] * P_DIV[i];
        tv = t + 2 * P_NCH[i];
        while (cyc < tv + 2) @(negedge clk110);
        check($sformatf("u%0d f%0d rd_count", i, nfr[i]), rd_ev[i].size(), n_rd);
        for (int j = 0; j < rd_ev[i].size() && j < n_rd; j++)
            check($sformatf("u%0d f%0d rd%0d_cyc", i, nfr[i], j), rd_ev[i][j], t + 1 + 2 * j);
        check($sformatf("u%0d f%0d valid_count", i, nfr[i]), vld_ev[i].size(), 1);
        if (vld_ev[i].size() > 0) begin
            check($sformatf("u%0d f%0d valid_cyc", i, nfr[i]), vld_ev[i][0], tv);
            check($sformatf("u%0d f%0d valid_sample", i, nfr[i]), vld_smp[i][0], exp_s);
        end
        check($sformatf("u%0d f%0d sample", i, nfr[i]), smp[i], exp_s);
        check($sformatf("u%0d f%0d underrun", i, nfr[i]), ucnt[i], uexp[i]);
        clear_events(i);
        nfr[i]++;
    endtask

    // Pushes n values from stim, predicts the committed frame, then checks it.
    task automatic play(input int i, input int n);
        logic [15:0] nm, d;
        logic [7:0]  e;
        nm = model_s[i];
        for (int j = 0; j < P_NCH[i]; j++) begin
            if (j < n) begin
                d = stim.pop_front();
                fq[i].push_back(d);
                e = model_conv(d, P_CONV[i], int'(vol[i]));
            end else begin
                e = (P_UH[i] != 0) ? model_s[i][j*8 +: 8] : 8'h80;
                if (uexp[i] != 16'hFFFF) uexp[i] = uexp[i] + 16'd1;
            end
            nm[j*8 +: 8] = e;
        end
        frame_check(i, nm, n);
        model_s[i] = nm;
    endtask

    initial begin
        int t;
        rst_n = '0;
        en    = '0;
        vol   = '0;

        repeat (3) @(negedge clk110);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset u%0d sample", i), smp[i], model_s[i]);
            check($sformatf("reset u%0d valid", i), vld[i], 1'b0);
            check($sformatf("reset u%0d rd", i), rd[i], 1'b0);
            check($sformatf("reset u%0d underrun", i), ucnt[i], 16'h0000);
        end

        // Default configuration: 0xAAAA at full volume decimates to 0xFF.
        start(0);
        stim.push_back(16'hAAAA);
        play(0, 1);
        check("u0 aaaa_full_scale", smp[0], 16'h00FF);
        for (int k = 0; k < 3; k++) begin
            vol[0] = 3'($urandom_range(0, 7));
            stim.push_back(16'($urandom));
            play(0, 1);
        end
        for (int k = 0; k < 3; k++) play(0, 0);
        check("u0 underrun_after_3", ucnt[0], 16'd3);

        @(negedge clk110);
        force u0.underrun_q = 16'hFFFE;
        #1;
        release u0.underrun_q;
        uexp[0] = 16'hFFFE;
        check("u0 underrun_preload", ucnt[0], 16'hFFFE);
        play(0, 0);
        play(0, 0);
        check("u0 underrun_saturated", ucnt[0], 16'hFFFF);
        vol[0] = 3'($urandom_range(0, 7));
        stim.push_back(16'($urandom));
        play(0, 1);
        en[0] = 1'b0;

        // MSB truncation with volume, including the attenuation extremes.
        vol[1] = 3'd1;
        start(1);
        stim.push_back(16'h1234);
        play(1, 1);
        check("u1 x1234_vol1", smp[1], 16'h0049);
        vol[1] = 3'd7;
        stim.push_back(16'h0000);
        play(1, 1);
        check("u1 zero_vol7", smp[1], 16'h007F);
        stim.push_back(16'hFFFF);
        play(1, 1);
        check("u1 full_vol7", smp[1], 16'h0080);
        for (int k = 0; k < 6; k++) begin
            vol[1] = 3'($urandom_range(0, 7));
            stim.push_back(16'($urandom));
            play(1, 1);
        end
        en[1] = 1'b0;

        // Two channels, midscale fill on underrun.
        vol[2] = 3'd0;
        start(2);
        stim.push_back(16'hFF00);
        stim.push_back(16'h00FF);
        play(2, 2);
        check("u2 two_channel", smp[2], 16'h00FF);
        for (int k = 0; k < 4; k++) begin
            vol[2] = 3'($urandom_range(0, 7));
            stim.push_back(16'($urandom));
            stim.push_back(16'($urandom));
            play(2, 2);
        end
        stim.push_back(16'($urandom));
        play(2, 1);
        play(2, 0);
        play(2, 0);
        check("u2 underrun_midscale", smp[2], 16'h8080);

        // Refill, then drop enable during the inter-channel gap.
        stim.push_back(16'($urandom));
        stim.push_back(16'($urandom));
        play(2, 2);
        fq[2].push_back(16'h1357);
        fq[2].push_back(16'h2468);
        t = base[2] + P_DIV[2] - 1 + nfr[2] * P_DIV[2];
        while (cyc < t + 2) @(negedge clk110);
        en[2] = 1'b0;
        repeat (8) @(negedge clk110);
        check("u2 abort rd_count", rd_ev[2].size(), 1);
        if (rd_ev[2].size() > 0) check("u2 abort rd_cyc", rd_ev[2][0], t + 1);
        check("u2 abort valid_count", vld_ev[2].size(), 0);
        check("u2 abort sample_kept", smp[2], model_s[2]);
        check("u2 abort fifo_left", fq[2].size(), 1);
        fq[2].delete();
        clear_events(2);
        start(2);
        stim.push_back(16'($urandom));
        stim.push_back(16'($urandom));
        play(2, 2);

        // Reset pulsed in the gap discards the partial frame.
        fq[2].push_back(16'hC3C3);
        fq[2].push_back(16'h3C3C);
        t = base[2] + P_DIV[2] - 1 + nfr[2] * P_DIV[2];
        while (cyc < t + 2) @(negedge clk110);
        rst_n[2] = 1'b0;
        repeat (3) @(negedge clk110);
        model_s[2] = 16'h8080;
        uexp[2]    = 16'h0000;
        check("u2 reset rd_count", rd_ev[2].size(), 1);
        if (rd_ev[2].size() > 0) check("u2 reset rd_cyc", rd_ev[2][0], t + 1);
        check("u2 reset valid_count", vld_ev[2].size(), 0);
        check("u2 reset sample", smp[2], 16'h8080);
        check("u2 reset underrun", ucnt[2], 16'h0000);
        fq[2].delete();
        clear_events(2);
        start(2);
        vol[2] = 3'($urandom_range(0, 7));
        stim.push_back(16'($urandom));
        play(2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
